// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writebacks with
// multi-cycle unit results, buffering the latter in a small FIFO with starvation control.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_FIFO,
    GRANT_PIPE,
    GRANT_BYPASS
  } grant_e;

  logic [4:0]       rd_mem   [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  grant_e      grant;
  logic        fifo_empty, fifo_full;
  logic        enq, deq;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign mdu_ready  = !fifo_full;

  // NOTE: combinational blocks assign every output a default first so no path infers a latch.
  always_comb begin
    grant    = GRANT_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (!fifo_empty && (fifo_full || starve_cnt == STV_LIMIT || !pipe_wb_valid)) begin
      grant    = GRANT_FIFO;
      sel_rd   = rd_mem[rd_ptr];
      sel_data = data_mem[rd_ptr];
    end else if (pipe_wb_valid) begin
      grant    = GRANT_PIPE;
      sel_rd   = pipe_wb_rd;
      sel_data = pipe_wb_data;
    end else if (mdu_valid && fifo_empty) begin
      grant    = GRANT_BYPASS;
      sel_rd   = mdu_rd;
      sel_data = mdu_data;
    end
  end

  assign pipe_stall = pipe_wb_valid && (grant != GRANT_PIPE);
  assign enq        = mdu_valid && mdu_ready && (grant != GRANT_BYPASS);
  assign deq        = (grant == GRANT_FIFO);

  // NOTE: FIFO storage has no reset; entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= mdu_rd;
      data_mem[wr_ptr] <= mdu_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);

      if (deq || fifo_empty)
        starve_cnt <= '0;
      else if (grant == GRANT_PIPE && starve_cnt != STV_LIMIT)
        starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Write port is registered; address and data hold on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant != GRANT_NONE) begin
      rf_we    <= (sel_rd != 5'd0);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 3;
  localparam int G_NONE = 0, G_FIFO = 1, G_PIPE = 2, G_BYP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, starvation as a plain integer.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  int          starve;
  int          exp_grant;
  logic        exp_stall, exp_ready, exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  task automatic model_reset();
    q.delete();
    starve    = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // Drive inputs shortly after an edge, then predict this cycle's combinational outputs.
  task automatic apply(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_wb_valid = pv; pipe_wb_rd = prd; pipe_wb_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #2;
    if (q.size() != 0 && (q.size() == DEPTH || starve == SMAX || !pv)) exp_grant = G_FIFO;
    else if (pv)                          exp_grant = G_PIPE;
    else if (mv && q.size() == 0)         exp_grant = G_BYP;
    else                                  exp_grant = G_NONE;
    exp_ready = (q.size() != DEPTH);
    exp_stall = pv && (exp_grant != G_PIPE);
  endtask

  // Clock once and update the model with the grant predicted in apply().
  task automatic advance();
    int     pre_size;
    entry_t e;
    pre_size = q.size();
    @(posedge clk);
    #1;
    case (exp_grant)
      G_FIFO: begin
        e = q.pop_front();
        exp_we = (e.rd != 0); exp_waddr = e.rd; exp_wdata = e.data;
      end
      G_PIPE: begin exp_we = (pipe_wb_rd != 0); exp_waddr = pipe_wb_rd; exp_wdata = pipe_wb_data; end
      G_BYP:  begin exp_we = (mdu_rd != 0); exp_waddr = mdu_rd; exp_wdata = mdu_data; end
      default: exp_we = 1'b0;
    endcase
    if (mdu_valid && pre_size != DEPTH && exp_grant != G_BYP)
      q.push_back('{rd: mdu_rd, data: mdu_data});
    if (exp_grant == G_FIFO || pre_size == 0) starve = 0;
    else if (exp_grant == G_PIPE)             starve = (starve < SMAX) ? starve + 1 : SMAX;
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    model_reset();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mdu_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_write();
    apply(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL pipe_stall: got %b want 0", pipe_stall); end
    advance();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_we: got %b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL pipe_waddr: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL pipe_wdata: got %h want 1234", rf_wdata); end
  endtask

  task automatic test_bypass();
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD);
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b want 1", mdu_ready); end
    advance();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL bypass_write: got we=%b addr=%0d want we=1 addr=7", rf_we, rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEAD) begin errors++; $display("FAIL bypass_wdata: got %h want dead", rf_wdata); end
    idle();
    advance();
    // A non-empty FIFO would be drained on this idle cycle.
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bypass_not_enqueued: got we=%b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL idle_hold_waddr: got %0d want 7", rf_waddr); end
  endtask

  task automatic test_starvation();
    apply(1'b1, 5'd3, 32'hA0, 1'b1, 5'd9, 32'h99);
    advance();
    for (int i = 1; i <= 4; i++) begin
      apply(1'b1, 5'd3, 32'hA0 + i, 1'b0, 5'd0, 32'd0);
      checks++;
      if (pipe_stall !== (i == 4)) begin errors++; $display("FAIL starve_stall[%0d]: got %b want %b", i, pipe_stall, (i == 4)); end
      advance();
    end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin errors++; $display("FAIL starve_write: got we=%b addr=%0d want we=1 addr=9", rf_we, rf_waddr); end
    checks++; if (rf_wdata !== 32'h99) begin errors++; $display("FAIL starve_wdata: got %h want 99", rf_wdata); end
    idle(); advance();
  endtask

  task automatic test_full_backpressure();
    apply(1'b1, 5'd10, 32'h10, 1'b1, 5'd1, 32'h111);
    advance();
    apply(1'b1, 5'd11, 32'h11, 1'b1, 5'd2, 32'h222);
    checks++; if (mdu_ready !== 1'b1 || pipe_stall !== 1'b0) begin errors++; $display("FAIL full_second_accept: got ready=%b stall=%b want 1 0", mdu_ready, pipe_stall); end
    advance();
    checks++; if (rf_waddr !== 5'd11) begin errors++; $display("FAIL full_pipe_write: got %0d want 11", rf_waddr); end
    apply(1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'd0);
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", mdu_ready); end
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", pipe_stall); end
    advance();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h111) begin errors++; $display("FAIL full_first: got we=%b addr=%0d data=%h want 1 1 111", rf_we, rf_waddr, rf_wdata); end
    idle();
    advance();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h222) begin errors++; $display("FAIL full_second: got we=%b addr=%0d data=%h want 1 2 222", rf_we, rf_waddr, rf_wdata); end
    idle(); advance();
  endtask

  task automatic test_x0();
    apply(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", pipe_stall); end
    advance();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", rf_we); end
  endtask

  task automatic test_random();
    logic [4:0] prd, mrd;
    for (int i = 0; i < 400; i++) begin
      prd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      mrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      apply($urandom_range(0, 99) < 60, prd, $urandom, $urandom_range(0, 99) < 45, mrd, $urandom);
      checks++; if (pipe_stall !== exp_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, pipe_stall, exp_stall); end
      checks++; if (mdu_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, mdu_ready, exp_ready); end
      advance();
      checks++;
      if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL rand_write[%0d]: got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                 i, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    apply(1'b1, 5'd13, 32'h13, 1'b1, 5'd3, 32'h333);
    advance();
    apply(1'b1, 5'd14, 32'h14, 1'b1, 5'd4, 32'h444);
    advance();
    idle();
    checks++; if (mdu_ready !== 1'b0 || rf_we !== 1'b1) begin errors++; $display("FAIL mid_setup: got ready=%b we=%b want 0 1", mdu_ready, rf_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we: got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL mid_reset_port: got addr=%0d data=%h want 0 0", rf_waddr, rf_wdata); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", mdu_ready); end
    for (int i = 0; i < 3; i++) begin
      idle();
      advance();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_stale_write[%0d]: got we=%b addr=%0d want we=0", i, rf_we, rf_waddr); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_bypass();
    test_starvation();
    test_full_backpressure();
    test_x0();
    test_random();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
